// File: rtl/mod_exp_pkg.sv
// Shared types and sizing helpers for the modular exponentiation sequencer.
package mod_exp_pkg;

   localparam int unsigned StateW = 4;

   typedef enum logic [StateW-1:0] {
      StIdle, StCheck, StScan, StSqr, StWaitSqr, StMul, StWaitMul, StNext, StFin
   } state_e;

   // Worst case is one square plus one multiply per exponent bit.
   localparam int unsigned MulsPerBit = 2;

   function automatic int unsigned min_cnt_bits(input int unsigned ebits);
      return $clog2(MulsPerBit * ebits + 1);
   endfunction

endpackage

// File: rtl/mod_exp_bitscan.sv
// Leading-one finder: index of the most significant set bit of the exponent.
module mod_exp_bitscan #(
   parameter int unsigned EBITS = 64,
   parameter int unsigned IW    = 6
) (
   input  logic [EBITS-1:0] exp,
   output logic [IW-1:0]    idx,
   output logic             found
);

   always_comb begin
      idx   = '0;
      found = 1'b0;
      for (int k = 0; k < EBITS; k++) begin
         if (exp[k]) begin
            idx   = IW'(k);
            found = 1'b1;
         end
      end
   end

endmodule

// File: rtl/mod_exp_ctrl.sv
// Left-to-right square-and-multiply sequencer driving an external modular multiplier.
// Define MOD_EXP_CT_EN for constant-time mode (square and multiply on every bit).
module mod_exp_ctrl
   import mod_exp_pkg::*;
#(
   parameter int unsigned NBITS = 4096,
   parameter int unsigned EBITS = 64,
   parameter int unsigned CBITS = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start_p,
   input  logic [NBITS-1:0] base,
   input  logic [EBITS-1:0] exp,
   input  logic [NBITS-1:0] m,
   output logic [NBITS-1:0] result,
   output logic             done_p,
   output logic             busy,
   output logic             err,
   output logic [CBITS-1:0] mul_cnt,
   output logic             mul_start_p,
   output logic [NBITS-1:0] mul_a,
   output logic [NBITS-1:0] mul_b,
   output logic [NBITS-1:0] mul_m,
   input  logic [NBITS-1:0] mul_y,
   input  logic             mul_done_p
);

   localparam int unsigned IW = (EBITS > 1) ? $clog2(EBITS) : 1;

   state_e           state_q, state_d;
   logic [NBITS-1:0] base_q, base_d, m_q, m_d, acc_q, acc_d, result_q, result_d;
   logic [NBITS-1:0] mul_a_q, mul_a_d, mul_b_q, mul_b_d, mul_m_q, mul_m_d;
   logic [EBITS-1:0] exp_q, exp_d;
   logic [IW-1:0]    i_q, i_d;
   logic [CBITS-1:0] cnt_q, cnt_d;
   logic             err_q, err_d;
   logic             illegal, m_is_one;

   assign illegal  = (m_q == '0) || (base_q >= m_q);
   assign m_is_one = (m_q == NBITS'(1));

`ifndef MOD_EXP_CT_EN
   logic [IW-1:0] lead_idx;
   logic          lead_found;

   mod_exp_bitscan #(
      .EBITS (EBITS),
      .IW    (IW)
   ) u_bitscan (
      .exp   (exp_q),
      .idx   (lead_idx),
      .found (lead_found)
   );
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= StIdle;
         base_q   <= '0;
         exp_q    <= '0;
         m_q      <= '0;
         acc_q    <= '0;
         result_q <= '0;
         mul_a_q  <= '0;
         mul_b_q  <= '0;
         mul_m_q  <= '0;
         i_q      <= '0;
         cnt_q    <= '0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         base_q   <= base_d;
         exp_q    <= exp_d;
         m_q      <= m_d;
         acc_q    <= acc_d;
         result_q <= result_d;
         mul_a_q  <= mul_a_d;
         mul_b_q  <= mul_b_d;
         mul_m_q  <= mul_m_d;
         i_q      <= i_d;
         cnt_q    <= cnt_d;
         err_q    <= err_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      base_d   = base_q;
      exp_d    = exp_q;
      m_d      = m_q;
      acc_d    = acc_q;
      result_d = result_q;
      mul_a_d  = mul_a_q;
      mul_b_d  = mul_b_q;
      mul_m_d  = mul_m_q;
      i_d      = i_q;
      cnt_d    = cnt_q;
      err_d    = err_q;
      unique case (state_q)
         StIdle: begin
            if (start_p) begin
               base_d  = base;
               exp_d   = exp;
               m_d     = m;
               err_d   = 1'b0;
               cnt_d   = '0;
               state_d = StCheck;
            end
         end
         StCheck: begin
            if (illegal) begin
               err_d    = 1'b1;
               result_d = '0;
               state_d  = StFin;
`ifdef MOD_EXP_CT_EN
            end else begin
               acc_d   = m_is_one ? '0 : NBITS'(1);
               i_d     = IW'(EBITS - 1);
               state_d = StSqr;
            end
`else
            end else if (!lead_found) begin
               result_d = m_is_one ? '0 : NBITS'(1);
               state_d  = StFin;
            end else begin
               i_d     = lead_idx;
               state_d = StScan;
            end
`endif
         end
         StScan: begin
            if (exp_q[i_q]) begin
               acc_d = base_q;
               if (i_q == '0) begin
                  result_d = base_q;
                  state_d  = StFin;
               end else begin
                  i_d     = i_q - IW'(1);
                  state_d = StSqr;
               end
            end else if (i_q != '0) begin
               i_d = i_q - IW'(1);
            end
         end
         StSqr: begin
            cnt_d   = cnt_q + CBITS'(1);
            state_d = StWaitSqr;
         end
         StWaitSqr: begin
            if (mul_done_p) begin
               acc_d = mul_y;
`ifdef MOD_EXP_CT_EN
               state_d = StMul;
`else
               state_d = exp_q[i_q] ? StMul : StNext;
`endif
            end
         end
         StMul: begin
            cnt_d   = cnt_q + CBITS'(1);
            state_d = StWaitMul;
         end
         StWaitMul: begin
            if (mul_done_p) begin
`ifdef MOD_EXP_CT_EN
               // Dummy multiply on zero bits: keep the squared value.
               acc_d = exp_q[i_q] ? mul_y : acc_q;
`else
               acc_d = mul_y;
`endif
               state_d = StNext;
            end
         end
         StNext: begin
            if (i_q == '0) begin
               result_d = acc_q;
               state_d  = StFin;
            end else begin
               i_d     = i_q - IW'(1);
               state_d = StSqr;
            end
         end
         StFin:   state_d = StIdle;
         default: state_d = StIdle;
      endcase
      // Operands are loaded one cycle ahead so they are stable from the start pulse onward.
      if (state_d == StSqr) begin
         mul_a_d = acc_d;
         mul_b_d = acc_d;
         mul_m_d = m_q;
      end else if (state_d == StMul) begin
         mul_a_d = acc_d;
         mul_b_d = base_q;
         mul_m_d = m_q;
      end
   end

   always_comb begin
      busy        = (state_q != StIdle);
      done_p      = (state_q == StFin);
      mul_start_p = (state_q == StSqr) || (state_q == StMul);
   end

   assign result  = result_q;
   assign err     = err_q;
   assign mul_cnt = cnt_q;
   assign mul_a   = mul_a_q;
   assign mul_b   = mul_b_q;
   assign mul_m   = mul_m_q;

endmodule

// File: tb/tb_mod_exp_ctrl.sv
// Self-checking bench for mod_exp_ctrl with a behavioural variable-latency multiplier.
module tb_mod_exp_ctrl;

   localparam int unsigned NBITS = 16;
   localparam int unsigned EBITS = 8;
   localparam int unsigned CBITS = 8;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             start_p = 1'b0;
   logic [NBITS-1:0] base = '0;
   logic [EBITS-1:0] exp = '0;
   logic [NBITS-1:0] m = '0;
   logic [NBITS-1:0] result;
   logic             done_p, busy, err;
   logic [CBITS-1:0] mul_cnt;
   logic             mul_start_p;
   logic [NBITS-1:0] mul_a, mul_b, mul_m;
   logic [NBITS-1:0] mul_y;
   logic             mul_done_p;

   int n_tests = 0;
   int n_fail  = 0;
   int unsigned mul_lat = 1;
   int unsigned done_seen = 0;
   logic spur_done = 1'b0;

   always #5 clk = ~clk;

   mod_exp_ctrl #(
      .NBITS (NBITS),
      .EBITS (EBITS),
      .CBITS (CBITS)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start_p     (start_p),
      .base        (base),
      .exp         (exp),
      .m           (m),
      .result      (result),
      .done_p      (done_p),
      .busy        (busy),
      .err         (err),
      .mul_cnt     (mul_cnt),
      .mul_start_p (mul_start_p),
      .mul_a       (mul_a),
      .mul_b       (mul_b),
      .mul_m       (mul_m),
      .mul_y       (mul_y),
      .mul_done_p  (mul_done_p)
   );

   // Behavioural multiplier: y = a*b mod m after mul_lat cycles.
   logic             mdone_q, pend_q;
   logic [NBITS-1:0] my_q, res_q;
   int unsigned      lat_q;
   assign mul_done_p = mdone_q | spur_done;
   assign mul_y      = my_q;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mdone_q <= 1'b0;
         pend_q  <= 1'b0;
         my_q    <= '0;
         res_q   <= '0;
         lat_q   <= 0;
      end else begin
         mdone_q <= 1'b0;
         if (mul_start_p) begin
            pend_q <= 1'b1;
            lat_q  <= mul_lat;
            res_q  <= (mul_m == 0) ? '0 :
                      NBITS'((longint'(mul_a) * longint'(mul_b)) % longint'(mul_m));
         end else if (pend_q) begin
            if (lat_q <= 1) begin
               pend_q  <= 1'b0;
               mdone_q <= 1'b1;
               my_q    <= res_q;
            end else begin
               lat_q <= lat_q - 1;
            end
         end
      end
   end

   always @(posedge clk) if (done_p) done_seen <= done_seen + 1;

   function automatic logic [NBITS-1:0] ref_pow(input longint b, input longint e, input longint mm);
      longint r;
      if (mm == 0 || b >= mm) return '0;
      r = 1 % mm;
      for (longint k = 0; k < e; k++) r = (r * b) % mm;
      return NBITS'(r);
   endfunction

   function automatic int ref_cnt(input longint b, input logic [EBITS-1:0] e, input longint mm);
      int msb;
      if (mm == 0 || b >= mm) return 0;
`ifdef MOD_EXP_CT_EN
      return 2 * EBITS;
`else
      if (e == 0) return 0;
      msb = 0;
      for (int k = 0; k < EBITS; k++) if (e[k]) msb = k;
      return msb + $countones(e) - 1;
`endif
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_tests++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
      end
   endtask

   task automatic wait_done(input string tag, output bit got);
      got = 1'b0;
      for (int c = 0; c < 20000; c++) begin
         if (done_p) begin
            got = 1'b1;
            break;
         end
         @(negedge clk);
      end
      chk({tag, " timeout"}, 32'(got), 32'd1);
   endtask

   task automatic check_end(input string tag, input logic [NBITS-1:0] b, input logic [EBITS-1:0] e,
                            input logic [NBITS-1:0] mm, input int unsigned d0);
      chk({tag, " result"}, 32'(result), 32'(ref_pow(b, e, mm)));
      chk({tag, " err"}, 32'(err), 32'((mm == 0) || (b >= mm)));
      chk({tag, " mul_cnt"}, 32'(mul_cnt), 32'(ref_cnt(b, e, mm)));
      @(negedge clk);
      chk({tag, " done_pulse"}, {30'd0, done_p, busy}, 32'd0);
      chk({tag, " done_count"}, done_seen - d0, 32'd1);
   endtask

   task automatic run_op(input string tag, input logic [NBITS-1:0] b, input logic [EBITS-1:0] e,
                         input logic [NBITS-1:0] mm);
      int unsigned d0;
      bit got;
      @(negedge clk);
      d0 = done_seen;
      base = b; exp = e; m = mm; start_p = 1'b1;
      @(negedge clk);
      start_p = 1'b0;
      chk({tag, " busy"}, 32'(busy), 32'd1);
      wait_done(tag, got);
      if (got) check_end(tag, b, e, mm, d0);
   endtask

   initial begin
      int unsigned d0;
      bit got;
      logic [NBITS-1:0] rm, rb;
      logic [EBITS-1:0] re;

      #12;
      chk("reset outs", {result, 12'd0, done_p, busy, err, mul_start_p}, 32'd0);
      chk("reset cnt", 32'(mul_cnt), 32'd0);
      chk("reset mul ops", 32'(mul_a | mul_b | mul_m), 32'd0);
      rst_n = 1'b1;

      run_op("pow_2_5", 16'd2, 8'd5, 16'd13);
      run_op("exp0", 16'd7, 8'd0, 16'd13);
      run_op("m1", 16'd0, 8'd3, 16'd1);
      run_op("base_eq_m", 16'd13, 8'd3, 16'd13);
      run_op("m0", 16'd5, 8'd3, 16'd0);
      run_op("exp1", 16'd9, 8'd1, 16'd13);
      run_op("exp_ff", 16'd12, 8'hff, 16'd13);

      // Second start while waiting on a square must be ignored.
      mul_lat = 6;
      @(negedge clk);
      d0 = done_seen;
      base = 16'd2; exp = 8'd5; m = 16'd13; start_p = 1'b1;
      @(negedge clk);
      start_p = 1'b0;
      got = 1'b0;
      for (int c = 0; c < 200 && !got; c++) begin
         if (mul_start_p) got = 1'b1;
         @(negedge clk);
      end
      chk("busy_start seen mul", 32'(got), 32'd1);
      base = 16'd5; exp = 8'd7; m = 16'd11; start_p = 1'b1;
      @(negedge clk);
      start_p = 1'b0;
      wait_done("busy_start", got);
      if (got) check_end("busy_start", 16'd2, 8'd5, 16'd13, d0);

      // Spurious multiplier completion while idle.
      d0 = done_seen;
      spur_done = 1'b1;
      @(negedge clk);
      spur_done = 1'b0;
      repeat (3) @(negedge clk);
      chk("spurious idle", {29'd0, busy, mul_start_p, done_p}, 32'd0);
      chk("spurious done_count", done_seen - d0, 32'd0);

      // Reset while a multiply is outstanding.
      mul_lat = 8;
      base = 16'd3; exp = 8'd200; m = 16'd251; start_p = 1'b1;
      @(negedge clk);
      start_p = 1'b0;
      got = 1'b0;
      for (int c = 0; c < 500 && !got; c++) begin
         if (mul_cnt == 2) got = 1'b1;
         else @(negedge clk);
      end
      chk("rst_mid reach", 32'(got), 32'd1);
      @(negedge clk);
      d0 = done_seen;
      rst_n = 1'b0;
      #1;
      chk("rst_mid outs", {result, 12'd0, done_p, busy, err, mul_start_p}, 32'd0);
      chk("rst_mid cnt", 32'(mul_cnt), 32'd0);
      chk("rst_mid mul ops", 32'(mul_a | mul_b | mul_m), 32'd0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (20) @(negedge clk);
      chk("rst_mid no done", done_seen - d0, 32'd0);
      mul_lat = 3;
      run_op("after_rst", 16'd3, 8'd200, 16'd251);

      for (int t = 0; t < 24; t++) begin
         mul_lat = $urandom_range(5, 1);
         rm = 16'($urandom_range(65535, 2));
         rb = 16'($urandom_range(32'(rm) - 1, 0));
         re = 8'($urandom_range(255, 0));
         if (t % 6 == 5) rb = rm;
         if (t % 8 == 7) rm = '0;
         run_op($sformatf("rand%0d", t), rb, re, rm);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
